wb_burst_master: RTL and testbench
==================================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter AW, 32, Wishbone address width in bits (byte address).
REQ-002 Parameter DW, 32, Wishbone data width; SW = DW/8 byte-select width.
REQ-003 Parameter BLW, 5, burst-length field width; beats per command = cmd_len+1 (1..2^BLW).
REQ-004 Parameter TMO, 255, timeout limit in cycles of stb without ack (1..65535).
REQ-005 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  AW  start byte address, DW-aligned.
REQ-010 cmd_len  in  BLW  beats minus one.
REQ-011 wdat_valid/wdat_ready  in/out  1/1  write-data handshake.
REQ-012 wdat_data  in  DW, wdat_sel  in  SW  write beat payload and byte enables.
REQ-013 rdat_valid  out  1, rdat_data  out  DW, rdat_last  out  1  read beat return; no backpressure.
REQ-014 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone B3 master controls.
REQ-015 wb_addr_o  out  AW, wb_dat_o  out  DW, wb_sel_o  out  SW, wb_cti_o  out  3.
REQ-016 wb_ack_i  in  1, wb_dat_i  in  DW  slave response.
REQ-017 busy_o  out  1 (state != IDLE); done_o  out  1 one-cycle completion pulse; err_o  out  1 valid with done_o.

Function
REQ-018 FSM states IDLE, WRITE, READ, DONE; all Wishbone outputs registered.
REQ-019 cmd_ready = 1 only in IDLE; on cmd_valid&cmd_ready, latch addr/len/we and enter WRITE (we=1) or READ (we=0) next cycle with wb_cyc_o=1, wb_we_o=cmd_we.
REQ-020 Beat counter beats_left loads cmd_len+1 (BLW+1 bits); decrements by 1 per cycle with wb_stb_o&wb_ack_i.
REQ-021 wb_addr_o loads cmd_addr, increments by SW on each acked beat; wraps modulo 2^AW, no error.
REQ-022 wb_cti_o = 3'b010 while beats_left > 1, 3'b111 while beats_left == 1 (single-beat command: 3'b111 throughout).
REQ-023 WRITE: wdat_ready = 1 when no beat is pending (wb_stb_o=0) or the pending beat is acked this cycle, and beats not yet loaded > 0.
REQ-024 WRITE: wdat handshake loads wb_dat_o/wb_sel_o and sets wb_stb_o next cycle; ack without a new handshake clears wb_stb_o; wb_cyc_o stays 1 during data gaps.
REQ-025 READ: wb_stb_o = 1 from entry until the final ack; wb_sel_o = all ones.
REQ-026 READ: each ack registers wb_dat_i into rdat_data with rdat_valid=1 for exactly one cycle after the ack; rdat_last=1 on the final beat only.
REQ-027 Final ack (beats_left == 1): wb_cyc_o and wb_stb_o = 0 next cycle; enter DONE; done_o=1, err_o=0 for one cycle; then IDLE.
REQ-028 Timeout counter counts consecutive cycles with wb_stb_o=1 and wb_ack_i=0; cleared on ack or on stb low.
REQ-029 Counter reaching TMO: drop wb_cyc_o/wb_stb_o next cycle, enter DONE, done_o=1, err_o=1; unloaded write data is not consumed.
REQ-030 wb_ack_i while wb_stb_o=0 or in IDLE/DONE is ignored (no count, no rdat_valid).
REQ-031 cmd_valid outside IDLE is not accepted; a command presented at the DONE cycle is accepted at the following IDLE cycle.

Reset
REQ-032 wb_rst_i=1 at an edge forces IDLE next cycle regardless of state, including mid-burst.
REQ-033 Reset values: wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_addr_o=0, wb_dat_o=0, wb_sel_o=0, wb_cti_o=0, cmd_ready=0 while reset is asserted, wdat_ready=0, rdat_valid=0, rdat_last=0, rdat_data=0, busy_o=0, done_o=0, err_o=0, counters=0.

Verification
REQ-034 Write cmd addr=0x100, len=3, wdat every cycle, ack every cycle -> 4 beats at 0x100/104/108/10C, cti 010,010,010,111, done_o=1 err_o=0.
REQ-035 Read cmd addr=0x200, len=0, ack after 3 wait cycles with dat=0xA5A5A5A5 -> cti=111, one rdat_valid with data 0xA5A5A5A5, rdat_last=1, done_o=1.
REQ-036 Write len=1 with a 2-cycle wdat gap between beats -> wb_stb_o low during gap, wb_cyc_o held 1, second beat at addr+4.
REQ-037 Read len=7, slave never acks, TMO=255 -> cyc/stb drop 256 cycles after stb rise, done_o=1 err_o=1, no rdat_valid.
REQ-038 Read len=7 at addr=0xFFFFFFF8 -> addresses wrap to 0x00000000 after 0xFFFFFFFC, 8 rdat beats, last flagged.
REQ-039 wb_rst_i asserted after beat 2 of a len=7 write -> next cycle cyc/stb=0, busy_o=0, no done_o; a new command is accepted after reset release.

Source files
------------

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 signal bundle between the burst master and the slave it drives.
// Names keep the master's _o/_i orientation so both sides read the same.
interface wb_burst_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: takes one read or write command and
// issues cmd_len+1 beats, with a stall timeout that aborts the burst.
module wb_burst_master #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BLW = 5,
    parameter int TMO = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // cmd_* and wdat_* transfer on a rising edge where valid and ready are both 1;
    // the source holds valid and payload stable until then. rdat_* has no ready.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [BLW-1:0]    cmd_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DW-1:0]     wdat_data,
    input  logic [DW/8-1:0]   wdat_sel,
    output logic              rdat_valid,
    output logic [DW-1:0]     rdat_data,
    output logic              rdat_last,
    wb_burst_master_if.master wb,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        state_dbg_o
);
    localparam int SW = DW / 8;
    localparam int CW = 16;
    localparam logic [BLW:0] ONE_BEAT = (BLW+1)'(1);
    localparam logic [2:0]   CTI_INCR = 3'b010;
    localparam logic [2:0]   CTI_END  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [2:0]      cti_q, cti_d;
    logic            rdat_valid_q, rdat_valid_d, rdat_last_q, rdat_last_d;
    logic [DW-1:0]   rdat_data_q, rdat_data_d;
    logic            done_q, done_d, err_q, err_d;
    logic [BLW:0]    beats_left_q, beats_left_d;
    logic [BLW:0]    loads_left_q, loads_left_d;
    logic [CW-1:0]   tmo_q, tmo_d;

    logic            ack_v, stall, timeout, final_ack, wdat_hs;
    logic [BLW:0]    cmd_beats;

    assign cmd_beats = {1'b0, cmd_len} + ONE_BEAT;
    // stb_q is only ever high in WRITE/READ, so acks elsewhere fall out here.
    assign ack_v     = stb_q & wb.wb_ack_i;
    assign stall     = stb_q & ~wb.wb_ack_i;
    assign timeout   = stall && (tmo_q == CW'(TMO));
    assign final_ack = ack_v && (beats_left_q == ONE_BEAT);

    assign cmd_ready  = (state_q == S_IDLE) && !wb_rst_i;
    assign wdat_ready = (state_q == S_WRITE) && !wb_rst_i && (!stb_q || wb.wb_ack_i)
                        && (loads_left_q != '0);
    assign wdat_hs    = wdat_valid && wdat_ready;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        addr_d       = addr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        cti_d        = cti_q;
        rdat_valid_d = 1'b0;
        rdat_data_d  = rdat_data_q;
        rdat_last_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        beats_left_d = beats_left_q;
        loads_left_d = loads_left_q;
        tmo_d        = stall ? tmo_q + CW'(1) : '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d      = cmd_we ? S_WRITE : S_READ;
                    cyc_d        = 1'b1;
                    stb_d        = ~cmd_we;
                    we_d         = cmd_we;
                    addr_d       = cmd_addr;
                    sel_d        = cmd_we ? sel_q : '1;
                    beats_left_d = cmd_beats;
                    loads_left_d = cmd_we ? cmd_beats : '0;
                    tmo_d        = '0;
                end
            end
            S_WRITE: begin
                // A new beat loaded in the ack cycle keeps stb up back-to-back.
                if (wdat_hs) begin
                    dat_d        = wdat_data;
                    sel_d        = wdat_sel;
                    stb_d        = 1'b1;
                    loads_left_d = loads_left_q - ONE_BEAT;
                end else if (ack_v) begin
                    stb_d = 1'b0;
                end
                if (ack_v) begin
                    beats_left_d = beats_left_q - ONE_BEAT;
                    addr_d       = addr_q + AW'(SW);
                end
            end
            S_READ: begin
                if (ack_v) begin
                    rdat_valid_d = 1'b1;
                    rdat_data_d  = wb.wb_dat_i;
                    rdat_last_d  = (beats_left_q == ONE_BEAT);
                    beats_left_d = beats_left_q - ONE_BEAT;
                    addr_d       = addr_q + AW'(SW);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (final_ack || timeout) begin
            state_d = S_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = timeout;
            tmo_d   = '0;
        end

        if (!cyc_d)                        cti_d = 3'b000;
        else if (beats_left_d > ONE_BEAT)  cti_d = CTI_INCR;
        else                               cti_d = CTI_END;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            cti_q        <= 3'b000;
            rdat_valid_q <= 1'b0;
            rdat_data_q  <= '0;
            rdat_last_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            beats_left_q <= '0;
            loads_left_q <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            cti_q        <= cti_d;
            rdat_valid_q <= rdat_valid_d;
            rdat_data_q  <= rdat_data_d;
            rdat_last_q  <= rdat_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
            beats_left_q <= beats_left_d;
            loads_left_q <= loads_left_d;
            tmo_q        <= tmo_d;
        end
    end

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = stb_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_cti_o  = cti_q;
    assign rdat_valid   = rdat_valid_q;
    assign rdat_data    = rdat_data_q;
    assign rdat_last    = rdat_last_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != S_IDLE);
    assign state_dbg_o  = state_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed and random bursts against a Wishbone slave
// model, compared with addresses/cti/data predicted from the burst rules.
module tb_wb_burst_master;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int BLW = 5;
    localparam int TMO = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [BLW-1:0]  cmd_len;
    logic            wdat_valid, wdat_ready;
    logic [DW-1:0]   wdat_data;
    logic [SW-1:0]   wdat_sel;
    logic            rdat_valid, rdat_last;
    logic [DW-1:0]   rdat_data;
    logic            busy_o, done_o, err_o;
    logic [1:0]      state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // scoreboard: expected streams from the bench, observed streams from the bus
    logic [DW-1:0]   exp_q[$];
    logic [SW-1:0]   exp_sel_q[$];
    logic [DW-1:0]   exp_rd_q[$];
    logic [AW-1:0]   obs_addr_q[$];
    logic [DW-1:0]   obs_dat_q[$];
    logic [SW-1:0]   obs_sel_q[$];
    logic [2:0]      obs_cti_q[$];
    logic            obs_we_q[$];
    logic [DW-1:0]   obs_rd_q[$];
    logic            obs_last_q[$];

    int last_cycles;
    int last_stb_n;
    bit last_gap_seen;

    wb_burst_master_if #(.AW(AW), .DW(DW)) bus ();

    wb_burst_master #(.AW(AW), .DW(DW), .BLW(BLW), .TMO(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdat_valid  (wdat_valid),
        .wdat_ready  (wdat_ready),
        .wdat_data   (wdat_data),
        .wdat_sel    (wdat_sel),
        .rdat_valid  (rdat_valid),
        .rdat_data   (rdat_data),
        .rdat_last   (rdat_last),
        .wb          (bus.master),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .state_dbg_o (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one command against the slave model, then checks it against the burst rules.
    task automatic run_cmd(input bit we, input logic [AW-1:0] addr, input int len,
                           input int wlo, input int whi, input int glo, input int ghi,
                           input bit no_ack, input int rst_after,
                           input bit use_pat, input logic [DW-1:0] pat);
        int acks = 0, sent = 0, cyc_n = 0, gap_left = 0, stb_n = 0, ready_wait = 0;
        int wait_left, n_exp, exp_sent;
        bit pend_rd = 0, done_seen = 0, err_seen = 0, cyc_bad = 0, rd_bad = 0;
        bit rst_hit = 0, wd_pend = 0, gap_seen = 0;
        logic [DW-1:0] rd;
        exp_q.delete(); exp_sel_q.delete(); exp_rd_q.delete();
        obs_addr_q.delete(); obs_dat_q.delete(); obs_sel_q.delete();
        obs_cti_q.delete(); obs_we_q.delete(); obs_rd_q.delete(); obs_last_q.delete();
        wait_left = $urandom_range(whi, wlo);

        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = BLW'(len);
        #1;
        while (cmd_ready !== 1'b1 && ready_wait < 20) begin
            next_cycle(); #1; ready_wait++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        next_cycle();
        cmd_valid = 1'b0;

        while (cyc_n < 2000) begin
            bus.wb_ack_i = 1'b0;
            if (rst_after > 0 && acks == rst_after) begin
                wdat_valid = 1'b0; rst = 1'b1;
                #1;
                check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
                check("rst_wdat_ready", 32'(wdat_ready), 32'd0);
                next_cycle();
                check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
                check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
                check("rst_busy", 32'(busy_o), 32'd0);
                check("rst_done", 32'(done_o), 32'd0);
                check("rst_state", 32'(state_dbg), 32'd0);
                rst = 1'b0; rst_hit = 1;
                break;
            end
            if (rdat_valid !== pend_rd) rd_bad = 1;
            if (rdat_valid === 1'b1) begin
                obs_rd_q.push_back(rdat_data); obs_last_q.push_back(rdat_last);
            end
            pend_rd = 0;
            if (done_o === 1'b1) begin
                done_seen = 1; err_seen = err_o; wdat_valid = 1'b0;
                break;
            end
            if (bus.wb_cyc_o !== 1'b1) cyc_bad = 1;
            if (bus.wb_stb_o !== 1'b1 && acks > 0) gap_seen = 1;
            if (bus.wb_stb_o === 1'b1) begin
                stb_n++;
                if (!no_ack) begin
                    if (wait_left == 0) begin
                        rd = use_pat ? pat : DW'($urandom());
                        bus.wb_ack_i = 1'b1; bus.wb_dat_i = rd;
                        obs_addr_q.push_back(bus.wb_addr_o); obs_dat_q.push_back(bus.wb_dat_o);
                        obs_sel_q.push_back(bus.wb_sel_o); obs_cti_q.push_back(bus.wb_cti_o);
                        obs_we_q.push_back(bus.wb_we_o);
                        if (!we) begin exp_rd_q.push_back(rd); pend_rd = 1; end
                        acks++;
                        wait_left = $urandom_range(whi, wlo);
                    end else begin
                        wait_left--;
                    end
                end
            end
            if (we) begin
                if (gap_left > 0) gap_left--;
                else if (!wd_pend && sent < len + 1) begin
                    wdat_data = DW'($urandom()); wdat_sel = SW'($urandom_range(15, 0));
                    wd_pend = 1;
                end
                wdat_valid = (gap_left == 0) && wd_pend;
            end
            #1;
            if (wdat_valid === 1'b1 && wdat_ready === 1'b1) begin
                exp_q.push_back(wdat_data); exp_sel_q.push_back(wdat_sel);
                sent++; wd_pend = 0; gap_left = $urandom_range(ghi, glo);
            end
            next_cycle();
            cyc_n++;
        end
        last_cycles = cyc_n; last_stb_n = stb_n; last_gap_seen = gap_seen;

        if (!rst_hit) begin
            check("done_seen", 32'(done_seen), 32'd1);
            check("err", 32'(err_seen), 32'(no_ack));
            check("done_cyc_low", 32'(bus.wb_cyc_o), 32'd0);
            check("done_stb_low", 32'(bus.wb_stb_o), 32'd0);
            #1;
            check("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
            n_exp = no_ack ? 0 : len + 1;
            check("beat_count", obs_addr_q.size(), n_exp);
            for (int i = 0; i < obs_addr_q.size() && i < n_exp; i++) begin
                check("beat_addr", obs_addr_q[i], addr + AW'(SW * i));
                check("beat_cti", 32'(obs_cti_q[i]), (i == len) ? 32'd7 : 32'd2);
                check("beat_we", 32'(obs_we_q[i]), 32'(we));
                if (we) begin
                    if (i < exp_q.size()) begin
                        check("beat_wdat", obs_dat_q[i], exp_q[i]);
                        check("beat_wsel", 32'(obs_sel_q[i]), 32'(exp_sel_q[i]));
                    end
                end else begin
                    check("beat_rsel", 32'(obs_sel_q[i]), 32'hF);
                end
            end
            if (we) begin
                exp_sent = no_ack ? 1 : len + 1;
                check("wdat_consumed", sent, exp_sent);
            end else begin
                check("rdat_count", obs_rd_q.size(), n_exp);
                for (int i = 0; i < obs_rd_q.size() && i < exp_rd_q.size(); i++) begin
                    check("rdat_data", obs_rd_q[i], exp_rd_q[i]);
                    check("rdat_last", 32'(obs_last_q[i]), (i == len) ? 32'd1 : 32'd0);
                end
            end
            check("rdat_timing", 32'(rd_bad), 32'd0);
            check("cyc_held", 32'(cyc_bad), 32'd0);
            next_cycle();
            check("done_pulse_one", 32'(done_o), 32'd0);
            check("idle_busy", 32'(busy_o), 32'd0);
            check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        logic [AW-1:0] raddr;
        bit            rwe;
        int            rlen;

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdat_valid = 1'b0; wdat_data = '0; wdat_sel = '0;
        bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0;
        repeat (3) next_cycle();

        // reset values
        check("rst_cyc_o", 32'(bus.wb_cyc_o), 32'd0);
        check("rst_stb_o", 32'(bus.wb_stb_o), 32'd0);
        check("rst_we_o", 32'(bus.wb_we_o), 32'd0);
        check("rst_addr_o", bus.wb_addr_o, 32'd0);
        check("rst_dat_o", bus.wb_dat_o, 32'd0);
        check("rst_sel_o", 32'(bus.wb_sel_o), 32'd0);
        check("rst_cti_o", 32'(bus.wb_cti_o), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_wdat_ready", 32'(wdat_ready), 32'd0);
        check("rst_rdat_valid", 32'(rdat_valid), 32'd0);
        check("rst_rdat_last", 32'(rdat_last), 32'd0);
        check("rst_rdat_data", rdat_data, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        next_cycle();

        // ack while idle must be ignored
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEADBEEF;
        next_cycle();
        check("idle_ack_rdat", 32'(rdat_valid), 32'd0);
        check("idle_ack_busy", 32'(busy_o), 32'd0);
        bus.wb_ack_i = 1'b0;
        next_cycle();
        check("idle_ack_rdat2", 32'(rdat_valid), 32'd0);

        // 4-beat write, data every cycle, ack every cycle
        run_cmd(1'b1, 32'h100, 3, 0, 0, 0, 0, 1'b0, 0, 1'b0, '0);
        check("wr4_latency", last_cycles, 5);

        // single-beat read acked after three wait cycles
        run_cmd(1'b0, 32'h200, 0, 3, 3, 0, 0, 1'b0, 0, 1'b1, 32'hA5A5A5A5);
        check("rd1_latency", last_cycles, 4);

        // two-beat write with a two-cycle data gap
        run_cmd(1'b1, 32'h300, 1, 0, 0, 2, 2, 1'b0, 0, 1'b0, '0);
        check("wr_gap_stb_low", 32'(last_gap_seen), 32'd1);

        // read that is never acked times out
        run_cmd(1'b0, 32'h400, 7, 0, 0, 0, 0, 1'b1, 0, 1'b0, '0);
        check("rd_tmo_stb_cycles", last_stb_n, TMO + 1);

        // write that is never acked leaves later data unconsumed
        run_cmd(1'b1, 32'h700, 3, 0, 0, 0, 0, 1'b1, 0, 1'b0, '0);
        check("wr_tmo_stb_cycles", last_stb_n, TMO + 1);

        // address wrap at the top of the space
        run_cmd(1'b0, 32'hFFFFFFF8, 7, 0, 2, 0, 0, 1'b0, 0, 1'b0, '0);

        // longest burst
        run_cmd(1'b1, 32'h1000, (1 << BLW) - 1, 0, 2, 0, 1, 1'b0, 0, 1'b0, '0);

        // reset after the second beat of an 8-beat write, then a fresh command
        run_cmd(1'b1, 32'h500, 7, 0, 0, 0, 0, 1'b0, 2, 1'b0, '0);
        run_cmd(1'b0, 32'h600, 2, 0, 1, 0, 0, 1'b0, 0, 1'b0, '0);

        // random bursts
        for (int k = 0; k < 12; k++) begin
            rwe   = 1'($urandom_range(1, 0));
            raddr = AW'($urandom());
            raddr[1:0] = 2'b00;
            rlen  = (k == 5) ? 31 : $urandom_range(7, 0);
            run_cmd(rwe, raddr, rlen, 0, 3, 0, 2, 1'b0, 0, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
